// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: takes a 16-bit word-count header plus little-endian words
// from a byte stream and holds the core in reset until a clean load. Optional: IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        cpu_hold
);

  localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_WRITE,
`ifdef IMEM_LOADER_CHECKSUM_EN
    S_CSUM,
`endif
    S_DONE
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] len, len_nxt;
  logic [ADDR_W:0] widx, widx_nxt;
  logic [1:0]  bidx, bidx_nxt;
  logic [31:0] wdata_nxt, addr_nxt;
  logic        err_nxt, hold_nxt;
  logic        xfer;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]  csum, csum_nxt;
`endif

  assign xfer = byte_valid & byte_ready;

  always_comb begin
    state_nxt = state;
    len_nxt   = len;
    widx_nxt  = widx;
    bidx_nxt  = bidx;
    wdata_nxt = mem_wdata;
    addr_nxt  = mem_addr;
    err_nxt   = error;
    hold_nxt  = cpu_hold;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_nxt  = csum;
`endif
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_nxt = S_LEN_LO;
          widx_nxt  = '0;
          bidx_nxt  = '0;
          err_nxt   = 1'b0;
          hold_nxt  = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_nxt  = '0;
`endif
        end
      end
      S_LEN_LO: begin
        if (xfer) begin
          len_nxt[7:0] = byte_data;
          state_nxt    = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (xfer) begin
          len_nxt[15:8] = byte_data;
          // Rejecting oversize headers here is what keeps the word index from wrapping.
          if ({1'b0, byte_data, len[7:0]} > MAX_WORDS) begin
            err_nxt   = 1'b1;
            state_nxt = S_DONE;
          end else if ({byte_data, len[7:0]} == 16'h0000) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_nxt = S_CSUM;
`else
            state_nxt = S_DONE;
            hold_nxt  = 1'b0;
`endif
          end else begin
            state_nxt = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (xfer) begin
          case (bidx)
            2'd0:    wdata_nxt[7:0]   = byte_data;
            2'd1:    wdata_nxt[15:8]  = byte_data;
            2'd2:    wdata_nxt[23:16] = byte_data;
            default: wdata_nxt[31:24] = byte_data;
          endcase
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_nxt = csum ^ byte_data;
`endif
          bidx_nxt = bidx + 2'd1;
          if (bidx == 2'd3) begin
            state_nxt = S_WRITE;
            addr_nxt  = '0;
            addr_nxt[ADDR_W+1:2] = widx[ADDR_W-1:0];
          end
        end
      end
      S_WRITE: begin
        widx_nxt = widx + {{ADDR_W{1'b0}}, 1'b1};
        if (17'(widx_nxt) < {1'b0, len}) begin
          state_nxt = S_DATA;
        end else begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_nxt = S_CSUM;
`else
          state_nxt = S_DONE;
          hold_nxt  = 1'b0;
`endif
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (xfer) begin
          state_nxt = S_DONE;
          if (byte_data != csum) begin
            err_nxt  = 1'b1;
          end else begin
            hold_nxt = 1'b0;
          end
        end
      end
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      len        <= '0;
      widx       <= '0;
      bidx       <= '0;
      mem_wdata  <= '0;
      mem_addr   <= '0;
      error      <= 1'b0;
      cpu_hold   <= 1'b1;
      byte_ready <= 1'b0;
      mem_we     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum       <= '0;
`endif
    end else begin
      state      <= state_nxt;
      len        <= len_nxt;
      widx       <= widx_nxt;
      bidx       <= bidx_nxt;
      mem_wdata  <= wdata_nxt;
      mem_addr   <= addr_nxt;
      error      <= err_nxt;
      cpu_hold   <= hold_nxt;
      mem_we     <= (state_nxt == S_WRITE);
      busy       <= (state_nxt != S_IDLE) && (state_nxt != S_DONE);
      done       <= (state_nxt == S_DONE);
`ifdef IMEM_LOADER_CHECKSUM_EN
      byte_ready <= (state_nxt == S_LEN_LO) || (state_nxt == S_LEN_HI) ||
                    (state_nxt == S_DATA)   || (state_nxt == S_CSUM);
      csum       <= csum_nxt;
`else
      byte_ready <= (state_nxt == S_LEN_LO) || (state_nxt == S_LEN_HI) ||
                    (state_nxt == S_DATA);
`endif
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with a write scoreboard; honours IMEM_LOADER_CHECKSUM_EN.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        busy;
  logic        done;
  logic        error;
  logic        cpu_hold;

  logic [63:0] exp_q[$];
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned wr_count = 0;
  int unsigned cycle    = 0;
  int unsigned last_we_cycle = 0;
  int unsigned prev_we_cycle = 0;
  int unsigned w0;
  logic [7:0]  tb_csum;

  imem_loader #(.ADDR_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .cpu_hold   (cpu_hold)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one clock, sample 1ns later, and score any write strobe.
  task automatic tick();
    logic [63:0] e;
    @(posedge clk);
    #1;
    cycle++;
    if (mem_we === 1'b1) begin
      wr_count++;
      prev_we_cycle = last_we_cycle;
      last_we_cycle = cycle;
      check("we_expected", {31'b0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("we_addr", mem_addr, e[63:32]);
        check("we_data", mem_wdata, e[31:0]);
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int unsigned n = 0;
    byte_valid = 1'b1;
    byte_data  = b;
    while (byte_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("byte_ready_wait", {31'b0, byte_ready}, 32'd1);
    tick();
    byte_valid = 1'b0;
    byte_data  = '0;
  endtask

  task automatic send_data_byte(input logic [7:0] b);
    tb_csum = tb_csum ^ b;
    send_byte(b);
  endtask

  task automatic send_word(input int unsigned idx, input logic [31:0] w);
    exp_q.push_back({idx[29:0], 2'b00, w});
    send_data_byte(w[7:0]);
    send_data_byte(w[15:8]);
    send_data_byte(w[23:16]);
    send_data_byte(w[31:24]);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    tb_csum = '0;
  endtask

  task automatic wait_done();
    int unsigned n = 0;
    while (done !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check("done_wait", {31'b0, done}, 32'd1);
  endtask

  task automatic send_csum_if_enabled();
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(tb_csum);
`endif
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_byte_ready"}, {31'b0, byte_ready}, 32'd0);
    check({tag, "_mem_we"},     {31'b0, mem_we},     32'd0);
    check({tag, "_mem_addr"},   mem_addr,            32'd0);
    check({tag, "_mem_wdata"},  mem_wdata,           32'd0);
    check({tag, "_busy"},       {31'b0, busy},       32'd0);
    check({tag, "_done"},       {31'b0, done},       32'd0);
    check({tag, "_error"},      {31'b0, error},      32'd0);
    check({tag, "_cpu_hold"},   {31'b0, cpu_hold},   32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    byte_valid = 1'b0;
    byte_data  = '0;
    tb_csum    = '0;
    #12;
    check_reset_values("rst");
    rst_n = 1'b1;
    tick();
    tick();

    // Two-word load with an unbroken stream.
    pulse_start();
    check("start_busy",     {31'b0, busy},       32'd1);
    check("start_ready",    {31'b0, byte_ready}, 32'd1);
    check("start_done",     {31'b0, done},       32'd0);
    send_byte(8'h02);
    send_byte(8'h00);
    send_word(0, 32'h00A00093);
    send_word(1, 32'h200006B7);
    send_csum_if_enabled();
    wait_done();
`ifdef IMEM_LOADER_CHECKSUM_EN
    check("done_latency", cycle - last_we_cycle, 32'd2);
`else
    check("done_latency", cycle - last_we_cycle, 32'd1);
`endif
    check("word_spacing", last_we_cycle - prev_we_cycle, 32'd5);
    check("n2_error",  {31'b0, error},      32'd0);
    check("n2_hold",   {31'b0, cpu_hold},   32'd0);
    check("n2_busy",   {31'b0, busy},       32'd0);
    check("n2_ready",  {31'b0, byte_ready}, 32'd0);
    check("n2_writes", wr_count,            32'd2);
    check("n2_queue",  exp_q.size(),        32'd0);

    // Oversize header: 257 words.
    w0 = wr_count;
    pulse_start();
    check("restart_hold",  {31'b0, cpu_hold}, 32'd1);
    check("restart_done",  {31'b0, done},     32'd0);
    send_byte(8'h01);
    send_byte(8'h01);
    wait_done();
    tick();
    check("big_error",  {31'b0, error},    32'd1);
    check("big_hold",   {31'b0, cpu_hold}, 32'd1);
    check("big_busy",   {31'b0, busy},     32'd0);
    check("big_writes", wr_count,          w0);

    // Error is cleared by the next start.
    pulse_start();
    check("start_clr_error", {31'b0, error}, 32'd0);

    // N=1 with byte_valid toggling every other cycle.
    w0 = wr_count;
    send_byte(8'h01); tick();
    send_byte(8'h00); tick();
    exp_q.push_back({32'h0, 32'h12345678});
    send_data_byte(8'h78); tick();
    send_data_byte(8'h56); tick();
    send_data_byte(8'h34); tick();
    send_data_byte(8'h12); tick();
    send_csum_if_enabled();
    wait_done();
    check("gap_error",  {31'b0, error},    32'd0);
    check("gap_hold",   {31'b0, cpu_hold}, 32'd0);
    check("gap_writes", wr_count,          w0 + 1);
    check("gap_queue",  exp_q.size(),      32'd0);

    // start pulses while busy, mid-word and during WRITE.
    w0 = wr_count;
    pulse_start();
    check("busy_hold_reassert", {31'b0, cpu_hold}, 32'd1);
    send_byte(8'h02);
    send_byte(8'h00);
    exp_q.push_back({32'h0, 32'hCAFEF00D});
    send_data_byte(8'h0D);
    send_data_byte(8'hF0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_start_ignored", {31'b0, busy}, 32'd1);
    send_data_byte(8'hFE);
    send_data_byte(8'hCA);
    start = 1'b1;
    tick();
    start = 1'b0;
    send_word(1, 32'h0BADBEEF);
    send_csum_if_enabled();
    wait_done();
    check("busy_start_error",  {31'b0, error}, 32'd0);
    check("busy_start_writes", wr_count,       w0 + 2);
    check("busy_start_queue",  exp_q.size(),   32'd0);

    // Reset after six data bytes of an N=2 load.
    w0 = wr_count;
    pulse_start();
    send_byte(8'h02);
    send_byte(8'h00);
    send_word(0, 32'hA5A50001);
    send_data_byte(8'h11);
    send_data_byte(8'h22);
    rst_n = 1'b0;
    #2;
    check_reset_values("midrst");
    check("midrst_writes", wr_count,     w0 + 1);
    check("midrst_queue",  exp_q.size(), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    pulse_start();
    send_byte(8'h01);
    send_byte(8'h00);
    send_word(0, 32'h00000513);
    send_csum_if_enabled();
    wait_done();
    check("reload_error",  {31'b0, error},    32'd0);
    check("reload_hold",   {31'b0, cpu_hold}, 32'd0);
    check("reload_writes", wr_count,          w0 + 2);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Checksum match and mismatch on N=1 bytes 13 00 00 00.
    pulse_start();
    send_byte(8'h01);
    send_byte(8'h00);
    send_word(0, 32'h00000013);
    send_byte(8'h13);
    wait_done();
    check("csum_ok_error", {31'b0, error},    32'd0);
    check("csum_ok_hold",  {31'b0, cpu_hold}, 32'd0);

    pulse_start();
    send_byte(8'h01);
    send_byte(8'h00);
    send_word(0, 32'h00000013);
    send_byte(8'h00);
    wait_done();
    check("csum_bad_error", {31'b0, error},    32'd1);
    check("csum_bad_hold",  {31'b0, cpu_hold}, 32'd1);
`endif

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
